// File: rtl/ad7124_spi_slave.sv
// ad7124_spi_slave: AD7124-style SPI responder, oversampled in the clk domain (clk >= 8x sclk).
// Build macro AD7124_SPI_SLAVE_ERRCNT_EN adds the err_cnt aborted-frame counter port.
module ad7124_spi_slave #(
  parameter bit CPOL        = 1'b1,
  parameter bit CPHA        = 1'b0,
  parameter int WIDTH       = 8,
  parameter int DATA_WD     = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  output logic [WIDTH-1:0]   cmd_o,
  output logic               cmd_valid,
  input  logic [DATA_WD-1:0] rsp_i,
  output logic               frame_done,
  output logic               frame_err,
`ifdef AD7124_SPI_SLAVE_ERRCNT_EN
  output logic [15:0]        err_cnt,
`endif
  output logic               busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RSP = 2'd2, DONE = 2'd3} state_t;

  localparam logic [7:0] CMD_LAST   = 8'(WIDTH - 1);
  localparam logic [7:0] FRAME_LAST = 8'(WIDTH + DATA_WD - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r, vld_r;
  logic                   sclk_prev_r, cs_prev_r, armed_r;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   rise_s, fall_s, lead_s, trail_s, sample_s, shift_s, cs_fall_s, cs_rise_s;

  state_t             state_r, state_n;
  logic [7:0]         cnt_r, cnt_n;
  logic [WIDTH-1:0]   shreg_r, shreg_n, cmd_r, cmd_n;
  logic [DATA_WD-1:0] tx_r, tx_n;
  logic               miso_r, miso_n, oe_r, oe_n;
  logic               cmd_valid_r, cmd_valid_n, done_r, done_n, err_r, err_n;
`ifdef AD7124_SPI_SLAVE_ERRCNT_EN
  logic [15:0]        err_cnt_r, err_cnt_n;
`endif

  assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s      = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
  assign rise_s    = sclk_s & ~sclk_prev_r;
  assign fall_s    = ~sclk_s & sclk_prev_r;
  assign lead_s    = CPOL ? fall_s : rise_s;
  assign trail_s   = CPOL ? rise_s : fall_s;
  assign sample_s  = ~cs_s & (CPHA ? trail_s : lead_s);
  assign shift_s   = ~cs_s & (CPHA ? lead_s : trail_s);
  // A cs fall only counts once cs has been seen high after reset, so a frame cut by reset is ignored.
  assign cs_fall_s = armed_r & ~cs_s & cs_prev_r;
  assign cs_rise_s = cs_s & ~cs_prev_r;

  // Pin synchronizers, edge-detect history and post-reset arming of cs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_r <= {SYNC_STAGES{CPOL}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= '0;
      vld_r       <= '0;
      sclk_prev_r <= CPOL;
      cs_prev_r   <= 1'b1;
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      vld_r       <= {vld_r[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
      armed_r     <= armed_r | (vld_r[SYNC_STAGES-1] & cs_s);
    end
  end

  // Frame FSM next-state and datapath; cs rise has priority over any coincident sclk edge.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    shreg_n     = shreg_r;
    tx_n        = tx_r;
    miso_n      = miso_r;
    oe_n        = oe_r;
    cmd_n       = cmd_r;
    cmd_valid_n = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    if ((state_r != IDLE) && cs_rise_s) begin
      state_n = IDLE;
      oe_n    = 1'b0;
      miso_n  = 1'b1;
      if (state_r == DONE) begin
        done_n = 1'b1;
      end else begin
        err_n = 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          miso_n = 1'b1;
          if (cs_fall_s) begin
            state_n = CMD;
            cnt_n   = 8'd0;
            oe_n    = 1'b1;
          end else begin
            oe_n = 1'b0;
          end
        end
        CMD: begin
          if (sample_s) begin
            shreg_n = {shreg_r[WIDTH-2:0], mosi_s};
            cnt_n   = cnt_r + 8'd1;
            if (cnt_r == CMD_LAST) begin
              cmd_n       = shreg_n;
              cmd_valid_n = 1'b1;
              tx_n        = rsp_i;
              state_n     = RSP;
            end else begin
              state_n = CMD;
            end
          end else begin
            state_n = CMD;
          end
        end
        RSP: begin
          if (shift_s) begin
            miso_n = tx_r[DATA_WD-1];
            tx_n   = {tx_r[DATA_WD-2:0], 1'b0};
          end else if (sample_s) begin
            cnt_n = cnt_r + 8'd1;
            if (cnt_r == FRAME_LAST) begin
              state_n = DONE;
              miso_n  = 1'b1;
            end else begin
              state_n = RSP;
            end
          end else begin
            state_n = RSP;
          end
        end
        DONE: begin
          miso_n = 1'b1;
          if (sample_s && (cnt_r != 8'hFF)) begin
            cnt_n = cnt_r + 8'd1;
          end else begin
            cnt_n = cnt_r;
          end
        end
        default: begin
          state_n = IDLE;
          oe_n    = 1'b0;
          miso_n  = 1'b1;
        end
      endcase
    end
  end

`ifdef AD7124_SPI_SLAVE_ERRCNT_EN
  // Aborted-frame counter: saturating, cleared by an all-ones command.
  always_comb begin
    err_cnt_n = err_cnt_r;
    if (err_n) begin
      err_cnt_n = (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
    end else if (cmd_valid_n && (cmd_n == {WIDTH{1'b1}})) begin
      err_cnt_n = 16'd0;
    end else begin
      err_cnt_n = err_cnt_r;
    end
  end
`endif

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      shreg_r     <= '0;
      tx_r        <= '0;
      miso_r      <= 1'b1;
      oe_r        <= 1'b0;
      cmd_r       <= '0;
      cmd_valid_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef AD7124_SPI_SLAVE_ERRCNT_EN
      err_cnt_r   <= 16'd0;
`endif
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      shreg_r     <= shreg_n;
      tx_r        <= tx_n;
      miso_r      <= miso_n;
      oe_r        <= oe_n;
      cmd_r       <= cmd_n;
      cmd_valid_r <= cmd_valid_n;
      done_r      <= done_n;
      err_r       <= err_n;
`ifdef AD7124_SPI_SLAVE_ERRCNT_EN
      err_cnt_r   <= err_cnt_n;
`endif
    end
  end

  assign miso       = miso_r;
  assign miso_oe    = oe_r;
  assign cmd_o      = cmd_r;
  assign cmd_valid  = cmd_valid_r;
  assign frame_done = done_r;
  assign frame_err  = err_r;
  assign busy       = (state_r != IDLE);
`ifdef AD7124_SPI_SLAVE_ERRCNT_EN
  assign err_cnt    = err_cnt_r;
`endif

endmodule
